// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet receive controller.
// Build option: UART_PKT_CHK_EN adds the trailing checksum byte and its CHK state.
package uart_pkt_pkg;

  // Default start-of-frame byte
  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

  // Error causes reported on Err_Code
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;
  localparam logic [1:0] ERR_OVF  = 2'd3;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
`ifdef UART_PKT_CHK_EN
    ST_PAYLOAD = 2'd2,
    ST_CHK     = 2'd3
`else
    ST_PAYLOAD = 2'd2
`endif
  } state_t;

  // Running XOR checksum step
  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_pkt_rx_ctrl_if.sv
// Byte-in / packet-out signal bundle for uart_pkt_rx_ctrl.
// slave: the controller. master: UART receiver plus packet consumer side.
interface uart_pkt_rx_ctrl_if;
  logic [7:0] Rx_Data;
  logic       Rx_Done;
  logic [7:0] Pkt_Data;
  logic       Pkt_Last;
  logic       Pkt_Valid;
  logic       Pkt_Ready;
  logic       Pkt_Ok;
  logic       Pkt_Err;
  logic [1:0] Err_Code;

  modport slave (
    input  Rx_Data, Rx_Done, Pkt_Ready,
    output Pkt_Data, Pkt_Last, Pkt_Valid, Pkt_Ok, Pkt_Err, Err_Code
  );

  modport master (
    output Rx_Data, Rx_Done, Pkt_Ready,
    input  Pkt_Data, Pkt_Last, Pkt_Valid, Pkt_Ok, Pkt_Err, Err_Code
  );
endinterface

// File: rtl/uart_pkt_buf.sv
// Staging buffer with three pointers: wr (speculative frame end), commit
// (end of validated data) and rd (consumer head). Only committed entries are
// visible to the reader; rollback discards everything past commit.
module uart_pkt_buf #(
  parameter int AW = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       wr_en,
  input  logic [8:0] wr_data,   // {last, byte}
  input  logic       commit,
  input  logic       rollback,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_last,
  output logic       full,
  output logic       valid
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] DEPTH_P = DEPTH[AW:0];

  logic [AW:0] wr_ptr_reg;
  logic [AW:0] commit_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [8:0]  mem [DEPTH];
  logic [8:0]  rd_entry;
  logic        wr_fire;

  // Full uses pre-read pointers so a same-cycle read never frees a slot for the write
  assign full    = ((wr_ptr_reg - rd_ptr_reg) == DEPTH_P);
  assign valid   = (rd_ptr_reg != commit_ptr_reg);
  assign wr_fire = wr_en && !full;

  // Head entry is masked to zero when nothing committed is waiting
  assign rd_entry = mem[rd_ptr_reg[AW-1:0]];
  assign rd_data  = valid ? rd_entry[7:0] : 8'h00;
  assign rd_last  = valid ? rd_entry[8]   : 1'b0;

  // Storage write; array left unreset so it maps onto RAM
  always_ff @(posedge Clk) begin
    if (wr_fire) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  // Pointer update; commit includes a write landing in the same cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      if (rollback)     wr_ptr_reg <= commit_ptr_reg;
      else if (wr_fire) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (commit)       commit_ptr_reg <= wr_ptr_reg + (AW+1)'(wr_fire);
      if (rd_en && valid) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_pkt_rx_ctrl.sv
// Frame sequencer: HDR, LEN, LEN payload bytes [, CHK]. Payload is staged in
// uart_pkt_buf and only committed once the frame completes cleanly; checksum
// mismatch, inter-byte timeout and buffer overflow roll the frame back.
// Build option: UART_PKT_CHK_EN enables the trailing XOR checksum byte.
module uart_pkt_rx_ctrl
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
  parameter int         FIFO_AW     = 4,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic               Clk,
  input  logic               Reset_n,
  uart_pkt_rx_ctrl_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state_reg, state_next;
  logic [7:0]    len_reg, len_next;
  logic [7:0]    byte_cnt_reg, byte_cnt_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          pkt_ok_reg, pkt_ok_next;
  logic          pkt_err_reg, pkt_err_next;
  logic [1:0]    err_code_reg, err_code_next;
`ifdef UART_PKT_CHK_EN
  logic [7:0]    chk_reg, chk_next;
`endif

  logic       buf_wr;
  logic [8:0] buf_wdata;
  logic       buf_commit;
  logic       buf_rollback;
  logic       buf_full;
  logic       buf_valid;
  logic       last_byte;
  logic       timeout_hit;

  uart_pkt_buf #(.AW(FIFO_AW)) u_buf (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .wr_en    (buf_wr),
    .wr_data  (buf_wdata),
    .commit   (buf_commit),
    .rollback (buf_rollback),
    .rd_en    (bus.Pkt_Ready),
    .rd_data  (bus.Pkt_Data),
    .rd_last  (bus.Pkt_Last),
    .full     (buf_full),
    .valid    (buf_valid)
  );

  assign bus.Pkt_Valid = buf_valid;
  assign bus.Pkt_Ok    = pkt_ok_reg;
  assign bus.Pkt_Err   = pkt_err_reg;
  assign bus.Err_Code  = err_code_reg;

  // PAYLOAD is only entered with len >= 1, so len-1 never underflows there
  assign last_byte   = (byte_cnt_reg == (len_reg - 8'd1));
  // A byte arriving on the expiry cycle wins over the timeout
  assign timeout_hit = (state_reg != ST_IDLE) && !bus.Rx_Done && (tmo_reg == TMO_LAST);

  // State and status registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= ST_IDLE;
      len_reg      <= '0;
      byte_cnt_reg <= '0;
      tmo_reg      <= '0;
      pkt_ok_reg   <= 1'b0;
      pkt_err_reg  <= 1'b0;
      err_code_reg <= ERR_NONE;
`ifdef UART_PKT_CHK_EN
      chk_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      byte_cnt_reg <= byte_cnt_next;
      tmo_reg      <= tmo_next;
      pkt_ok_reg   <= pkt_ok_next;
      pkt_err_reg  <= pkt_err_next;
      err_code_reg <= err_code_next;
`ifdef UART_PKT_CHK_EN
      chk_reg      <= chk_next;
`endif
    end
  end

  // Next-state, buffer control and commit/rollback decisions
  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    byte_cnt_next = byte_cnt_reg;
    pkt_ok_next   = 1'b0;
    pkt_err_next  = 1'b0;
    err_code_next = err_code_reg;
    buf_wr        = 1'b0;
    buf_wdata     = {last_byte, bus.Rx_Data};
    buf_commit    = 1'b0;
    buf_rollback  = 1'b0;
`ifdef UART_PKT_CHK_EN
    chk_next      = chk_reg;
`endif
    // Idle counter only runs inside a frame and restarts on every byte
    if (state_reg == ST_IDLE || bus.Rx_Done) tmo_next = '0;
    else                                     tmo_next = tmo_reg + TW'(1);

    if (timeout_hit) begin
      buf_rollback  = 1'b1;
      pkt_err_next  = 1'b1;
      err_code_next = ERR_TMO;
      tmo_next      = '0;
      state_next    = ST_IDLE;
    end else if (bus.Rx_Done) begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.Rx_Data == HDR_BYTE) state_next = ST_LEN;
        end
        ST_LEN: begin
          len_next      = bus.Rx_Data;
          byte_cnt_next = '0;
`ifdef UART_PKT_CHK_EN
          chk_next      = bus.Rx_Data;
          state_next    = (bus.Rx_Data == 8'd0) ? ST_CHK : ST_PAYLOAD;
`else
          if (bus.Rx_Data == 8'd0) begin
            buf_commit  = 1'b1;
            pkt_ok_next = 1'b1;
            state_next  = ST_IDLE;
          end else begin
            state_next  = ST_PAYLOAD;
          end
`endif
        end
        ST_PAYLOAD: begin
          if (buf_full) begin
            buf_rollback  = 1'b1;
            pkt_err_next  = 1'b1;
            err_code_next = ERR_OVF;
            state_next    = ST_IDLE;
          end else begin
            buf_wr        = 1'b1;
            byte_cnt_next = byte_cnt_reg + 8'd1;
`ifdef UART_PKT_CHK_EN
            chk_next      = chk_update(chk_reg, bus.Rx_Data);
            if (last_byte) state_next = ST_CHK;
`else
            if (last_byte) begin
              buf_commit  = 1'b1;
              pkt_ok_next = 1'b1;
              state_next  = ST_IDLE;
            end
`endif
          end
        end
`ifdef UART_PKT_CHK_EN
        ST_CHK: begin
          if (bus.Rx_Data == chk_reg) begin
            buf_commit    = 1'b1;
            pkt_ok_next   = 1'b1;
          end else begin
            buf_rollback  = 1'b1;
            pkt_err_next  = 1'b1;
            err_code_next = ERR_CHK;
          end
          state_next = ST_IDLE;
        end
`endif
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_rx_ctrl.sv
// Directed bench for uart_pkt_rx_ctrl (FIFO_AW=2, TIMEOUT_CYC=100).
// Frames carry the CHK byte only when UART_PKT_CHK_EN is defined.
module tb_uart_pkt_rx_ctrl;

`ifdef UART_PKT_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic Clk;
  logic Reset_n;
  uart_pkt_rx_ctrl_if bus();

  uart_pkt_rx_ctrl #(
    .HDR_BYTE    (8'hA5),
    .FIFO_AW     (2),
    .TIMEOUT_CYC (100)
  ) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  bit valid_seen = 1'b0;
  logic [8:0] rx_q[$];
  logic last_ok, last_err;

  // Monitor between edges: inputs change on negedge, so +2 sees what the next posedge sees
  always begin
    @(negedge Clk);
    #2;
    if (Reset_n) begin
      if (bus.Pkt_Ok)  ok_cnt++;
      if (bus.Pkt_Err) err_cnt++;
      if (bus.Pkt_Valid) valid_seen = 1'b1;
      if (bus.Pkt_Valid && bus.Pkt_Ready) rx_q.push_back({bus.Pkt_Last, bus.Pkt_Data});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [8:0] exp);
    logic [8:0] v;
    chk({tag, "_avail"}, 32'(rx_q.size() > 0), 1);
    if (rx_q.size() > 0) begin
      v = rx_q.pop_front();
      chk(tag, 32'(v), 32'(exp));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One Rx_Done pulse plus one gap cycle; records Ok/Err seen the cycle after
  task automatic send_byte(input logic [7:0] b);
    bus.Rx_Data = b;
    bus.Rx_Done = 1'b1;
    @(negedge Clk);
    last_ok  = bus.Pkt_Ok;
    last_err = bus.Pkt_Err;
    bus.Rx_Done = 1'b0;
    @(negedge Clk);
  endtask

  // pl holds payload little-end first: pl[7:0] is sent first
  task automatic send_frame(input logic [7:0] len, input logic [63:0] pl, input logic [7:0] cs);
    send_byte(8'hA5);
    send_byte(len);
    for (int i = 0; i < int'(len); i++) send_byte(pl[8*i +: 8]);
    if (CHK_EN) send_byte(cs);
  endtask

  int e0, o0, waited;
  bit got;

  initial begin
    Reset_n       = 1'b0;
    bus.Rx_Data   = 8'h00;
    bus.Rx_Done   = 1'b0;
    bus.Pkt_Ready = 1'b1;
    last_ok  = 1'b0;
    last_err = 1'b0;
    idle(3);

    // Reset values
    chk("rst_valid", bus.Pkt_Valid, 0);
    chk("rst_last",  bus.Pkt_Last, 0);
    chk("rst_ok",    bus.Pkt_Ok, 0);
    chk("rst_err",   bus.Pkt_Err, 0);
    chk("rst_code",  bus.Err_Code, 0);
    chk("rst_data",  bus.Pkt_Data, 0);
    Reset_n = 1'b1;
    idle(2);

    // Good frame A5 03 11 22 33 [03]
    send_frame(8'd3, 64'h332211, 8'h03);
    chk("f1_ok_next_cycle", last_ok, 1);
    idle(6);
    chk("f1_ok_cnt", ok_cnt, 1);
    chk("f1_err_cnt", err_cnt, 0);
    chk_pop("f1_d0", 9'h011);
    chk_pop("f1_d1", 9'h022);
    chk_pop("f1_d2", 9'h133);
    chk("f1_q_empty", rx_q.size(), 0);
    chk("f1_code", bus.Err_Code, 0);

`ifdef UART_PKT_CHK_EN
    // Bad checksum A5 03 11 22 33 04
    valid_seen = 1'b0;
    o0 = ok_cnt;
    send_frame(8'd3, 64'h332211, 8'h04);
    chk("f2_err_next_cycle", last_err, 1);
    idle(6);
    chk("f2_code", bus.Err_Code, 1);
    chk("f2_no_valid", valid_seen, 0);
    chk("f2_no_ok", ok_cnt, o0);
`endif

    // Timeout: A5 02 11 then silence
    valid_seen = 1'b0;
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    got = 1'b0;
    waited = 0;
    for (int i = 0; i < 150 && !got; i++) begin
      @(negedge Clk);
      waited++;
      if (bus.Pkt_Err) got = 1'b1;
    end
    chk("tmo_err_seen", got, 1);
    chk("tmo_window", 32'(waited >= 90 && waited <= 105), 1);
    chk("tmo_code", bus.Err_Code, 2);
    idle(3);
    chk("tmo_err_cnt", err_cnt, e0 + 1);
    chk("tmo_no_valid", valid_seen, 0);

    // Recovery A5 01 7E [7F]; Err_Code keeps the timeout cause
    send_frame(8'd1, 64'h7E, 8'h7F);
    chk("rec_ok", last_ok, 1);
    idle(4);
    chk_pop("rec_d0", 9'h17E);
    chk("rec_code_held", bus.Err_Code, 2);

    // Exactly full: A5 04 01 02 03 04 [00] with Ready=0 commits all four
    bus.Pkt_Ready = 1'b0;
    send_frame(8'd4, 64'h04030201, 8'h00);
    chk("full4_ok", last_ok, 1);
    chk("full4_valid", bus.Pkt_Valid, 1);
    chk("full4_head", bus.Pkt_Data, 8'h01);
    chk("full4_head_last", bus.Pkt_Last, 0);
    bus.Pkt_Ready = 1'b1;
    idle(6);
    chk_pop("full4_d0", 9'h001);
    chk_pop("full4_d1", 9'h002);
    chk_pop("full4_d2", 9'h003);
    chk_pop("full4_d3", 9'h104);
    chk("full4_drained", bus.Pkt_Valid, 0);

    // Overflow: Ready=0, A5 05 01..05, error on the 5th payload byte
    bus.Pkt_Ready = 1'b0;
    o0 = ok_cnt;
    send_byte(8'hA5);
    send_byte(8'h05);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    chk("ovf_no_err_yet", last_err, 0);
    send_byte(8'h05);
    chk("ovf_err", last_err, 1);
    chk("ovf_code", bus.Err_Code, 3);
    chk("ovf_empty", bus.Pkt_Valid, 0);
    if (CHK_EN) send_byte(8'h04);
    bus.Pkt_Ready = 1'b1;
    idle(4);
    chk("ovf_no_ok", ok_cnt, o0);
    chk("ovf_q_empty", rx_q.size(), 0);

    // Zero-length frame A5 00 [00]
    valid_seen = 1'b0;
    send_frame(8'd0, 64'h0, 8'h00);
    chk("len0_ok", last_ok, 1);
    idle(4);
    chk("len0_no_valid", valid_seen, 0);

    // Garbage before header: 00 FF, then A5 01 55 [54]
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'd1, 64'h55, 8'h54);
    chk("garb_ok", last_ok, 1);
    idle(4);
    chk_pop("garb_d0", 9'h155);
    chk("garb_q_empty", rx_q.size(), 0);

    // Mid-frame reset with committed data still buffered
    bus.Pkt_Ready = 1'b0;
    send_frame(8'd1, 64'h99, 8'h98);
    chk("mr_buffered", bus.Pkt_Valid, 1);
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h01);
    Reset_n = 1'b0;
    idle(2);
    chk("mr_valid", bus.Pkt_Valid, 0);
    chk("mr_data",  bus.Pkt_Data, 0);
    chk("mr_code",  bus.Err_Code, 0);
    chk("mr_err",   bus.Pkt_Err, 0);
    Reset_n = 1'b1;
    bus.Pkt_Ready = 1'b1;
    idle(2);
    chk("mr_no_err_pulse", err_cnt, e0);

    // Clean frame after reset: A5 02 AA BB [13]
    send_frame(8'd2, 64'hBBAA, 8'h13);
    chk("post_ok", last_ok, 1);
    idle(5);
    chk_pop("post_d0", 9'h0AA);
    chk_pop("post_d1", 9'h1BB);
    chk("post_q_empty", rx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
